// File: rtl/operand_loader.sv
// Board-input front end: synchronises and debounces two keys, then latches
// adder operands A and B from the switches on successive load presses.
module operand_loader #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         key_n,
    input  logic [2*WIDTH-1:0] sw,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               valid,
    output logic [1:0]         state
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        READY  = 2'd2,
        BAD    = 2'd3
    } state_t;

    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    stable_q, stable_d;
    logic [1:0]    stable_dly_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    press;
    logic          load_ev, clr_ev;

    state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic          valid_q, valid_d;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Event only on the released-to-pressed transition of the debounced level
    assign press   = stable_dly_q & ~stable_q;
    assign load_ev = press[0];
    assign clr_ev  = press[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            stable_q     <= 2'b11;
            stable_dly_q <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q      <= key_n;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_ev) begin
            state_d = WAIT_A;
        end else begin
            unique case (state_q)
                WAIT_A:  if (load_ev) state_d = WAIT_B;
                WAIT_B:  if (load_ev) state_d = READY;
                READY:   if (load_ev) state_d = WAIT_B;
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        if (clr_ev || state_q == BAD) begin
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else if (load_ev) begin
            unique case (state_q)
                WAIT_A: a_d = sw[2*WIDTH-1:WIDTH];
                WAIT_B: begin
                    b_d     = sw[WIDTH-1:0];
                    valid_d = 1'b1;
                end
                READY: begin
                    a_d     = sw[2*WIDTH-1:WIDTH];
                    valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign valid = valid_q;
    assign state = state_q;

endmodule

// File: doc/operand_loader.md
# operand_loader

Board-input front end for the 5-bit adder datapath. Debounces and synchronises the two push-buttons, then runs a small state machine that latches operand A and operand B from the slide switches on successive presses of key 0. It presents stable registered operands plus a valid flag to the adder, and key 1 clears everything. Switch activity between presses never reaches the adder.

## Interface

- `WIDTH`, default 5: operand width; the switch bus is 2*WIDTH.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a key level change (1 ms at 50 MHz). Must be ≥ 2.

- `clk`  in  1  board clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_n`  in  2  raw push-buttons, active-low, asynchronous. [0] = load, [1] = clear.
- `sw`  in  2*WIDTH  raw slide switches. Upper half is A, lower half is B.
- `a`  out  WIDTH  latched operand A.
- `b`  out  WIDTH  latched operand B.
- `valid`  out  1  high while both operands are latched (state READY).
- `state`  out  2  FSM state for LED display: 0 WAIT_A, 1 WAIT_B, 2 READY.

## Operation

- **Synchroniser:** two flops per key, reset to 1 (released).
- **Debouncer, per key:**
  - Holds a `stable` level (reset 1) and a counter (reset 0).
  - Each cycle the synced value differs from `stable`, the counter increments.
  - Each cycle they match, the counter clears to 0.
  - When a mismatch cycle finds the counter at DEBOUNCE_CYCLES-1, `stable` takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- **Press event:** a one-cycle pulse when `stable` goes 1→0. A held key gives exactly one event. Release gives no event.
- **FSM** (registered; reset state WAIT_A, `a`=0, `b`=0, `valid`=0):
  - WAIT_A + load event: `a` <= sw[2W-1:W]; go to WAIT_B.
  - WAIT_B + load event: `b` <= sw[W-1:0]; go to READY; `valid` <= 1.
  - READY + load event: `a` <= sw[2W-1:W]; keep `b`; `valid` <= 0; go to WAIT_B.
  - Clear event, any state: `a`=0, `b`=0, `valid`=0, go to WAIT_A.
  - Clear wins over a load event in the same cycle.
  - The encoding value 3 is unreachable; if entered, go to WAIT_A with the clear actions.
- `sw` is sampled only on a load event and otherwise has no effect on any output.

## Timing

- **Reset:** `rst` sampled high clears all registers at that edge. Outputs read `a`=0, `b`=0, `valid`=0, `state`=0 from then on. Reset mid-debounce discards the partial count.
- **Press latency:** let edge 1 be the first edge sampling `key_n` low.
  - Synced low after edge 2.
  - `stable` flips at edge DEBOUNCE_CYCLES+2.
  - The event pulse is high for the following cycle.
  - `a`/`b`/`valid`/`state` update at edge DEBOUNCE_CYCLES+3.
- **Release** needs DEBOUNCE_CYCLES stable cycles before another press can be accepted.
- **Key held through reset:** the first post-reset edge counts as edge 1, and one event fires per the latency above.
- Simultaneous events on both keys are resolved in a single cycle. No event is queued or lost except a load that a clear overrides.
- All outputs are direct register outputs with no combinational path from inputs.

## Test plan

All scenarios run with DEBOUNCE_CYCLES=4.

- **Reset:** hold `rst` 2 cycles with `key_n`=11 and `sw`=3FF. Expect `a`=0, `b`=0, `valid`=0, `state`=0; no change over 20 idle cycles.
- **Load A then B:** `sw`=10110_01011; `key_n`[0] low 10 cycles then high 10 cycles.
  - At edge 7: `a`=22, `state`=1, `valid`=0.
  - Change `sw` to 00000_01011 and press again: `b`=11, `state`=2, `valid`=1, `a` still 22.
- **Bounce rejection:** `key_n`[0] pattern low 3, high 1, low 3, high 1 produces no change. A following 6-cycle low produces exactly one event: `state` 0→1 at the 7th edge of that low run.
- **Clear from READY:** press `key_n`[1]. At edge 7: `a`=0, `b`=0, `valid`=0, `state`=0.
- **Simultaneous events:** in WAIT_B, drive both keys low on the same cycle for 8 cycles. Clear wins: `state`=0, `a`=0, `b`=0, with no load observed.
- **Reset mid-debounce:** hold `key_n`[0] low 3 cycles, pulse `rst` 1 cycle, keep the key low. Outputs stay at reset values until one event fires 7 edges after the first post-reset edge (`state`=1).
